fpu_operand_loader: RTL

Upstream feeder for the FPU add/sub core. Accepts operand pairs in IEEE-754 single precision through a valid/ready handshake and converts each operand into the core's 32-bit format: sign [31], exponent [30:25] with bias 31, mantissa [24:0] with an implicit leading 1. It flags inputs that are unrepresentable in that format and holds the converted pair stable until the consumer takes it.

---
 rtl/fpu_operand_loader.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fpu_operand_loader.sv
// Operand loader for the FPU add/sub core: takes an IEEE-754 single pair over valid/ready,
// converts each operand into the core's bias-31 format over two cycles, and holds the result.
module fpu_operand_loader #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a_ieee,
    input  logic [31:0]      in_b_ieee,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      op_A_out,
    output logic [31:0]      op_B_out,
    output logic [3:0]       status_out,
    output logic [CNT_W-1:0] exc_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV_A = 2'd1,
        CONV_B = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      op_a_q, op_a_d;
    logic [31:0]      op_b_q, op_b_d;
    logic [3:0]       flags_q, flags_d;
    logic [3:0]       status_q, status_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [35:0]      conv_a_s;
    logic [35:0]      conv_b_s;
    logic [3:0]       status_new_s;

    // Returns {flags[3:0], value[31:0]}; flags are {zero, underflow, overflow, invalid}.
    function automatic logic [35:0] convert(input logic [31:0] x);
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
        logic [8:0]  ex;
        logic [3:0]  fl;
        logic [31:0] v;
        s  = x[31];
        e  = x[30:23];
        f  = x[22:0];
        ex = {1'b0, e} - 9'd96;
        fl = 4'b0000;
        v  = 32'd0;
        if (e == 8'd0) begin
            v  = {s, 31'd0};
            fl = (f != 23'd0) ? 4'b1100 : 4'b1000;
        end else if (e == 8'hFF) begin
            if (f == 23'd0) begin
                v  = {s, 6'h3F, 25'h1FF_FFFF};
                fl = 4'b0010;
            end else begin
                v  = 32'd0;
                fl = 4'b0001;
            end
        end else if ($signed(ex) <= $signed(9'sd0)) begin
            v  = {s, 31'd0};
            fl = 4'b1100;
        end else if ($signed(ex) <= $signed(9'sd63)) begin
            v  = {s, ex[5:0], f, 2'b00};
            fl = 4'b0000;
        end else begin
            v  = {s, 6'h3F, 25'h1FF_FFFF};
            fl = 4'b0010;
        end
        return {fl, v};
    endfunction

    assign conv_a_s     = convert(a_q);
    assign conv_b_s     = convert(b_q);
    assign status_new_s = flags_q | conv_b_s[35:32];

    // Next-state and datapath update for the four-phase load sequence.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        flags_d  = flags_q;
        status_d = status_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = in_a_ieee;
                    b_d      = in_b_ieee;
                    flags_d  = 4'b0000;
                    status_d = 4'b0000;
                    state_d  = CONV_A;
                end else begin
                    state_d  = IDLE;
                end
            end
            CONV_A: begin
                op_a_d  = conv_a_s[31:0];
                flags_d = flags_q | conv_a_s[35:32];
                state_d = CONV_B;
            end
            CONV_B: begin
                op_b_d   = conv_b_s[31:0];
                flags_d  = status_new_s;
                status_d = status_new_s;
                if ((status_new_s[2:0] != 3'b000) && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
                state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Handshake flags are registered copies of the next state, so they track state alone.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == HOLD);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            op_a_q      <= 32'd0;
            op_b_q      <= 32'd0;
            flags_q     <= 4'b0000;
            status_q    <= 4'b0000;
            cnt_q       <= {CNT_W{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            flags_q     <= flags_d;
            status_q    <= status_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign op_A_out   = op_a_q;
    assign op_B_out   = op_b_q;
    assign status_out = status_q;
    assign exc_count  = cnt_q;

endmodule
